alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 4-bit ALU (4-bit opcode, two 4-bit operands, 6-bit result) among N_REQ requesters. It accepts one request at a time and captures that requester's opcode and operands. It drives the ALU, waits a fixed ALU latency, then returns the 6-bit result to the winning requester with a one-cycle valid pulse. It sits between the client blocks and the shared ALU instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
ALU_LAT, 1, ALU clock edges from inputs stable to result valid (0 = combinational ALU)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req  in  N_REQ  per-requester request level
req_opcode  in  4*N_REQ  opcode, requester i at bits [4i+3:4i]
req_a  in  4*N_REQ  operand A, same packing
req_b  in  4*N_REQ  operand B, same packing
gnt  out  N_REQ  one-hot grant pulse, one cycle
rsp_valid  out  N_REQ  one-hot result-valid pulse, one cycle
rsp_result  out  6  result of the last completed transaction
busy  out  1  high while a transaction is in flight (BUSY or RESP)
alu_opcode  out  4  to ALU Opcode
alu_a  out  4  to ALU OperandA
alu_b  out  4  to ALU OperandB
alu_result  in  6  from ALU Result

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset state: all outputs 0, state IDLE, wait counter 0, priority pointer so requester 0 has highest priority. A reset asserted mid-transaction aborts it: no rsp_valid pulse, back to IDLE on the next edge.
- States: IDLE, BUSY, RESP. All outputs are registered.
- IDLE:
  - On an edge with any req bit high, select the winner by round robin: search starts at (last_winner+1) mod N_REQ.
  - Capture that requester's opcode, A and B into alu_opcode/alu_a/alu_b.
  - Set gnt[winner]=1, busy=1, counter=0, go BUSY.
  - With no req, remain in IDLE and hold alu_* at their last values.
- BUSY:
  - gnt is high only in the first BUSY cycle.
  - alu_* held stable throughout.
  - The counter increments each edge. When counter==ALU_LAT, sample alu_result into rsp_result, set rsp_valid[winner]=1, go RESP.
  - Latency: req sampled at edge E0 gives gnt high after E0, and rsp_valid high after edge E0+ALU_LAT+1.
- RESP: rsp_valid is high for exactly this one cycle. Next edge: clear rsp_valid and busy, update last_winner to the winner, go IDLE.
- rsp_result holds its value until the next completed transaction.
- Handshake: requesters keep req, opcode and operands stable until gnt is seen. Operands are captured at the grant edge, so changes after that are ignored.
- A req that drops during BUSY does not cancel the transaction; the response is still delivered.
- A req still high in IDLE after its rsp_valid is treated as a new transaction.
- Throughput: one transaction per ALU_LAT+3 cycles. Requests arriving during BUSY/RESP wait; none are lost while req is held.
- Fairness: with all N_REQ requesting continuously, grants rotate 0,1,2,...,N_REQ-1,0. No requester waits more than N_REQ-1 transactions.
- Opcode and operands are passed unmodified. The arbiter does not interpret opcodes.
- Result is 6 bits, the same width as the ALU output. No truncation or extension.

Optional Feature:
ALU_ARB_PRIO0_EN:
- Defined: requester 0 is always granted when its req is high in IDLE, overriding round robin. The pointer is not updated on a requester-0 win, so rotation among the others resumes where it left off.
- Not defined: pure round robin as above.

Test Plan:
- Bench ALU model returns {2'b00,A}+{2'b00,B}. ALU_LAT=1. req=4'b0001, A=4'd5, B=4'd1 -> gnt=0001 one cycle after the request edge; rsp_valid=0001 two cycles after gnt; rsp_result=6'd6; busy high 3 cycles.
- req=4'b1111 held with distinct operands -> gnt sequence 0001,0010,0100,1000,0001. Each rsp_valid matches the preceding gnt. Spacing of 4 cycles between grants.
- Requester 2 drops req the cycle after gnt and changes A to 4'd0 -> response still pulses on rsp_valid[2] with the result from the originally captured operands.
- rst asserted during the BUSY cycle of a requester-1 transaction -> no rsp_valid. All outputs 0 the next cycle. The next grant with req=4'b1111 goes to requester 0.
- ALU_LAT=0 with the same stimulus as scenario 1 -> rsp_valid one cycle after gnt.
- ALU_ARB_PRIO0_EN defined, req=4'b1111 held -> grants 0001,0001,...; with req[0] low after the first grant -> 0010,0100,1000 rotation.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Client/ALU bundle for alu_arbiter. The slave modport is the arbiter; the master
// modport is its surroundings (requesting clients plus the shared ALU).
interface alu_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [4*N_REQ-1:0] req_opcode;
    logic [4*N_REQ-1:0] req_a;
    logic [4*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   rsp_valid;
    logic [5:0]         rsp_result;
    logic               busy;
    logic [3:0]         alu_opcode;
    logic [3:0]         alu_a;
    logic [3:0]         alu_b;
    logic [5:0]         alu_result;

    modport master (
        output req, req_opcode, req_a, req_b, alu_result,
        input  gnt, rsp_valid, rsp_result, busy, alu_opcode, alu_a, alu_b
    );

    modport slave (
        input  req, req_opcode, req_a, req_b, alu_result,
        output gnt, rsp_valid, rsp_result, busy, alu_opcode, alu_a, alu_b
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one 4-bit ALU among N_REQ requesters.
// Build option ALU_ARB_PRIO0_EN: requester 0 wins whenever it requests in IDLE.
module alu_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave io
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAT_C    = CNT_W'(ALU_LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] win_q, win_d;
    logic             upd_q, upd_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [5:0]       rsp_result_q, rsp_result_d;
    logic             busy_q, busy_d;
    logic [3:0]       alu_opcode_q, alu_opcode_d;
    logic [3:0]       alu_a_q, alu_a_d;
    logic [3:0]       alu_b_q, alu_b_d;

    logic [IDX_W-1:0] idx_s, pick_s;
    logic             pick_upd_s;
    logic [3:0]       sel_op_s, sel_a_s, sel_b_s;

    // Winner selection and operand mux for the requester that would be granted now
    always_comb begin
        idx_s      = {IDX_W{1'b0}};
        pick_s     = {IDX_W{1'b0}};
        pick_upd_s = 1'b1;
        // Walk from farthest to nearest so the nearest requester after last_q wins
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx_s  = IDX_W'((int'(last_q) + 1 + i) % N_REQ);
            pick_s = io.req[idx_s] ? idx_s : pick_s;
        end
`ifdef ALU_ARB_PRIO0_EN
        if (io.req[0]) begin
            pick_s     = {IDX_W{1'b0}};
            pick_upd_s = 1'b0;
        end else begin
            pick_upd_s = 1'b1;
        end
`endif
        sel_op_s = 4'd0;
        sel_a_s  = 4'd0;
        sel_b_s  = 4'd0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_op_s = (pick_s == IDX_W'(i)) ? io.req_opcode[4*i +: 4] : sel_op_s;
            sel_a_s  = (pick_s == IDX_W'(i)) ? io.req_a[4*i +: 4]      : sel_a_s;
            sel_b_s  = (pick_s == IDX_W'(i)) ? io.req_b[4*i +: 4]      : sel_b_s;
        end
    end

    // Next-state and next-output computation for the IDLE/BUSY/RESP sequencer
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        win_d        = win_q;
        upd_d        = upd_q;
        gnt_d        = {N_REQ{1'b0}};
        rsp_valid_d  = {N_REQ{1'b0}};
        rsp_result_d = rsp_result_q;
        busy_d       = busy_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        case (state_q)
            S_IDLE: begin
                if (|io.req) begin
                    state_d      = S_BUSY;
                    cnt_d        = {CNT_W{1'b0}};
                    win_d        = pick_s;
                    upd_d        = pick_upd_s;
                    gnt_d        = ONE_HOT0 << pick_s;
                    busy_d       = 1'b1;
                    alu_opcode_d = sel_op_s;
                    alu_a_d      = sel_a_s;
                    alu_b_d      = sel_b_s;
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_BUSY: begin
                if (cnt_q == LAT_C) begin
                    state_d      = S_RESP;
                    rsp_result_d = io.alu_result;
                    rsp_valid_d  = ONE_HOT0 << win_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                last_d  = upd_q ? win_q : last_q;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs; rst abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            last_q       <= IDX_W'(N_REQ - 1);
            win_q        <= {IDX_W{1'b0}};
            upd_q        <= 1'b0;
            gnt_q        <= {N_REQ{1'b0}};
            rsp_valid_q  <= {N_REQ{1'b0}};
            rsp_result_q <= 6'd0;
            busy_q       <= 1'b0;
            alu_opcode_q <= 4'd0;
            alu_a_q      <= 4'd0;
            alu_b_q      <= 4'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            win_q        <= win_d;
            upd_q        <= upd_d;
            gnt_q        <= gnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            busy_q       <= busy_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
        end
    end

    assign io.gnt        = gnt_q;
    assign io.rsp_valid  = rsp_valid_q;
    assign io.rsp_result = rsp_result_q;
    assign io.busy       = busy_q;
    assign io.alu_opcode = alu_opcode_q;
    assign io.alu_a      = alu_a_q;
    assign io.alu_b      = alu_b_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: an ALU_LAT=1 and an ALU_LAT=0 instance share stimulus and
// are compared every cycle against a transaction-timeline model, plus directed literals.
`timescale 1ns/1ps
module tb_alu_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [4*N-1:0] op  = '0;
    logic [4*N-1:0] a   = '0;
    logic [4*N-1:0] b   = '0;
    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.N_REQ(N)) if_l1 ();
    alu_arbiter_if #(.N_REQ(N)) if_l0 ();

    assign if_l1.req = req;
    assign if_l1.req_opcode = op;
    assign if_l1.req_a = a;
    assign if_l1.req_b = b;
    assign if_l0.req = req;
    assign if_l0.req_opcode = op;
    assign if_l0.req_a = a;
    assign if_l0.req_b = b;

    // Bench ALU: A+B, one register stage for the latency-1 instance, combinational for the other
    logic [5:0] alu_l1_q = 6'd0;
    always @(posedge clk) alu_l1_q <= {2'b00, if_l1.alu_a} + {2'b00, if_l1.alu_b};
    assign if_l1.alu_result = alu_l1_q;
    assign if_l0.alu_result = {2'b00, if_l0.alu_a} + {2'b00, if_l0.alu_b};

    alu_arbiter #(.N_REQ(N), .ALU_LAT(1)) dut_l1 (.clk(clk), .rst(rst), .io(if_l1));
    alu_arbiter #(.N_REQ(N), .ALU_LAT(0)) dut_l0 (.clk(clk), .rst(rst), .io(if_l0));

    // Model: m_t = edges since the grant edge (-1 = never granted since reset).
    // gnt at t=0, rsp_valid at t=L+1, idle again from t=L+2.
    int         m_t[2], m_last[2], m_win[2];
    bit         m_upd[2];
    logic [3:0] m_op[2], m_a[2], m_b[2];
    logic [5:0] m_res[2];
    int g_cyc[$], g_idx[$], r_cyc[$], r_idx[$];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s lat=%0d cyc=%0d got=%0h expected=%0h", name, lat_of(k), cyc, act, exp);
        end
    endtask

    task automatic model_edge(input int k);
        int L;
        int p;
        L = lat_of(k);
        if (rst) begin
            m_t[k] = -1; m_last[k] = N - 1; m_win[k] = 0; m_upd[k] = 1'b0;
            m_op[k] = 4'd0; m_a[k] = 4'd0; m_b[k] = 4'd0; m_res[k] = 6'd0;
        end else if (m_t[k] >= 0 && m_t[k] <= L + 1) begin
            m_t[k] = m_t[k] + 1;
            if (m_t[k] == L + 1) m_res[k] = {2'b00, m_a[k]} + {2'b00, m_b[k]};
            if (m_t[k] == L + 2 && m_upd[k]) m_last[k] = m_win[k];
        end else if (req != '0) begin
            m_win[k] = -1;
            for (int j = 1; j <= N; j++) begin
                p = (m_last[k] + j) % N;
                if (m_win[k] < 0 && req[p]) m_win[k] = p;
            end
            m_upd[k] = 1'b1;
`ifdef ALU_ARB_PRIO0_EN
            if (req[0]) begin
                m_win[k] = 0;
                m_upd[k] = 1'b0;
            end
`endif
            m_t[k]  = 0;
            m_op[k] = op[4*m_win[k] +: 4];
            m_a[k]  = a[4*m_win[k] +: 4];
            m_b[k]  = b[4*m_win[k] +: 4];
        end
    endtask

    // Compare process: advance model on each edge, check both DUTs 1 ns later
    initial begin
        logic [N-1:0] eg, ev;
        forever begin
            @(posedge clk);
            model_edge(0);
            model_edge(1);
            #1;
            cyc++;
            for (int k = 0; k < 2; k++) begin
                eg = (m_t[k] == 0) ? (N'(1) << m_win[k]) : '0;
                ev = (m_t[k] == lat_of(k) + 1) ? (N'(1) << m_win[k]) : '0;
                chk("gnt", k, (k == 0) ? if_l1.gnt : if_l0.gnt, eg);
                chk("rsp_valid", k, (k == 0) ? if_l1.rsp_valid : if_l0.rsp_valid, ev);
                chk("rsp_result", k, (k == 0) ? if_l1.rsp_result : if_l0.rsp_result, m_res[k]);
                chk("busy", k, (k == 0) ? if_l1.busy : if_l0.busy,
                    (m_t[k] >= 0 && m_t[k] <= lat_of(k) + 1) ? 1 : 0);
                chk("alu_opcode", k, (k == 0) ? if_l1.alu_opcode : if_l0.alu_opcode, m_op[k]);
                chk("alu_a", k, (k == 0) ? if_l1.alu_a : if_l0.alu_a, m_a[k]);
                chk("alu_b", k, (k == 0) ? if_l1.alu_b : if_l0.alu_b, m_b[k]);
            end
            for (int i = 0; i < N; i++) begin
                if (if_l1.gnt[i] === 1'b1) begin
                    g_cyc.push_back(cyc);
                    g_idx.push_back(i);
                end
                if (if_l1.rsp_valid[i] === 1'b1) begin
                    r_cyc.push_back(cyc);
                    r_idx.push_back(i);
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [3:0] o, input logic [3:0] av, input logic [3:0] bv);
        op[4*i +: 4] = o;
        a[4*i +: 4]  = av;
        b[4*i +: 4]  = bv;
    endtask

    task automatic wait_for(input string name, input bit want_rv, input int i);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 16 && !ok; c++) begin
            @(negedge clk);
            ok = want_rv ? (if_l1.rsp_valid[i] === 1'b1) : (if_l1.gnt[i] === 1'b1);
        end
        chk(name, 0, ok, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        g_cyc.delete(); g_idx.delete(); r_cyc.delete(); r_idx.delete();
    endtask

    initial begin
        logic [N-1:0] g1[1:6], v1[1:6], g0[1:6], v0[1:6];
        logic [5:0]   r1[1:6], r0[1:6];
        int busy1, busy0;
        int exp_seq[5];

        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single request from requester 0: 5 + 1
        set_req(0, 4'h3, 4'd5, 4'd1);
        req = 4'b0001;
        busy1 = 0;
        busy0 = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) req = 4'b0000;
            g1[c] = if_l1.gnt; v1[c] = if_l1.rsp_valid; r1[c] = if_l1.rsp_result;
            g0[c] = if_l0.gnt; v0[c] = if_l0.rsp_valid; r0[c] = if_l0.rsp_result;
            busy1 += int'(if_l1.busy);
            busy0 += int'(if_l0.busy);
        end
        chk("s1_gnt", 0, g1[1], 4'b0001);
        chk("s1_gnt_one_cycle", 0, g1[2], 4'b0000);
        chk("s1_rv_not_early", 0, v1[2], 4'b0000);
        chk("s1_rv", 0, v1[3], 4'b0001);
        chk("s1_result", 0, r1[3], 6'd6);
        chk("s1_busy_cycles", 0, busy1, 3);
        chk("s1_gnt", 1, g0[1], 4'b0001);
        chk("s1_rv", 1, v0[2], 4'b0001);
        chk("s1_result", 1, r0[2], 6'd6);
        chk("s1_busy_cycles", 1, busy0, 2);

        // All four requesting continuously with distinct operands
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 4'(i + 8), 4'(3 * i + 2), 4'(15 - i));
        clear_logs();
        req = 4'b1111;
        repeat (24) @(negedge clk);
        req = 4'b0000;
`ifdef ALU_ARB_PRIO0_EN
        exp_seq = '{0, 0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 2, 3, 0};
`endif
        chk("s2_grant_count", 0, (g_idx.size() >= 5 && r_idx.size() >= 5) ? 1 : 0, 1);
        if (g_idx.size() >= 5 && r_idx.size() >= 5) begin
            for (int j = 0; j < 5; j++) begin
                chk("s2_grant_order", 0, g_idx[j], exp_seq[j]);
                chk("s2_rsp_matches_gnt", 0, r_idx[j], g_idx[j]);
                chk("s2_rsp_delay", 0, r_cyc[j] - g_cyc[j], 2);
                if (j > 0) chk("s2_grant_spacing", 0, g_cyc[j] - g_cyc[j-1], 4);
            end
        end
        repeat (8) @(negedge clk);

        // Requester 2 drops req and changes A right after its grant
        set_req(2, 4'hA, 4'd9, 4'd4);
        req = 4'b0100;
        wait_for("s3_gnt2", 1'b0, 2);
        req = 4'b0000;
        a[11:8] = 4'd0;
        wait_for("s3_rv2", 1'b1, 2);
        chk("s3_result", 0, if_l1.rsp_result, 6'd13);
        chk("s3_alu_a_held", 0, if_l1.alu_a, 4'd9);
        repeat (4) @(negedge clk);

        // Reset during the BUSY cycle of a requester-1 transaction
        set_req(1, 4'h5, 4'd3, 4'd7);
        req = 4'b0010;
        wait_for("s4_gnt1", 1'b0, 1);
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("s4_gnt_zero", k, (k == 0) ? if_l1.gnt : if_l0.gnt, 0);
            chk("s4_rv_zero", k, (k == 0) ? if_l1.rsp_valid : if_l0.rsp_valid, 0);
            chk("s4_busy_zero", k, (k == 0) ? if_l1.busy : if_l0.busy, 0);
            chk("s4_result_zero", k, (k == 0) ? if_l1.rsp_result : if_l0.rsp_result, 0);
            chk("s4_alu_a_zero", k, (k == 0) ? if_l1.alu_a : if_l0.alu_a, 0);
            chk("s4_alu_op_zero", k, (k == 0) ? if_l1.alu_opcode : if_l0.alu_opcode, 0);
        end
        rst = 1'b0;
        req = 4'b1111;
        @(negedge clk);
        chk("s4_next_gnt", 0, if_l1.gnt, 4'b0001);
        chk("s4_next_gnt", 1, if_l0.gnt, 4'b0001);
        chk("s4_no_rv", 0, if_l1.rsp_valid, 4'b0000);
        req = 4'b0000;
        repeat (6) @(negedge clk);

        // Requester 0 wins first, then drops out: rotation over 1,2,3
        do_reset();
        req = 4'b1111;
        wait_for("s6_gnt0", 1'b0, 0);
        req = 4'b1110;
        clear_logs();
        repeat (16) @(negedge clk);
        req = 4'b0000;
        chk("s6_grant_count", 0, (g_idx.size() >= 3) ? 1 : 0, 1);
        if (g_idx.size() >= 3) begin
            for (int j = 0; j < 3; j++) chk("s6_grant_order", 0, g_idx[j], j + 1);
        end
        repeat (6) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
